nzcv_cond_unit: RTL and testbench
=================================

# nzcv_cond_unit

Consumer side of the ALU status path. It captures the N/Z/C/V flags produced in EX, including the Z bit from the 64-bit zero detector, and holds them in a one-entry pending stage before committing them to the architectural NZCV register. It resolves B.cond, CBZ and CBNZ from the youngest valid flags through bypassing, so a branch directly behind an ADDS/SUBS sees that instruction's result with no stall. It sits between the EX-stage ALU and the fetch redirect logic of the pipelined core.

## Interface
Parameters:
- RESET_NZCV, 4'b0000, architectural NZCV value after reset.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  squash the EX instruction and the pending stage this cycle.
- ex_valid  in  1  EX holds a live instruction.
- ex_set_flags  in  1  the EX instruction writes flags (ADDS/SUBS/ANDS).
- ex_nzcv  in  4  ALU flags as {N,Z,C,V}. Z comes from the zero detector.
- br_valid  in  1  a branch is requesting resolution.
- br_kind  in  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 unconditional B.
- br_cond  in  4  AArch64 cond field; used only for B.cond.
- br_reg_zero  in  1  zero-detect of the CBZ/CBNZ operand register.
- br_taken  out  1  branch resolves taken.
- nzcv_arch  out  4  committed NZCV.
- nzcv_fwd  out  4  flags the branch actually used (bypass result).

## Operation
- Flags storage:
  - pend_valid/pend_nzcv: one-entry pending stage.
  - arch_nzcv: the architectural register.
- Capture: when ex_valid & ex_set_flags & !flush, the next state is pend_valid=1 and pend_nzcv=ex_nzcv. Otherwise pend_valid=0.
- Commit: when pend_valid & !flush, arch_nzcv takes pend_nzcv on the next edge. A flush discards the pending entry, and arch_nzcv holds its value.
- Bypass priority for nzcv_fwd:
  - live EX setter (ex_valid & ex_set_flags & !flush) → ex_nzcv;
  - else pend_valid & !flush → pend_nzcv;
  - else arch_nzcv.
- Condition decode on nzcv_fwd, with cond[3:1] as the base test and cond[0]=1 inverting it:
  - 000 EQ: Z
  - 001 CS: C
  - 010 MI: N
  - 011 VS: V
  - 100 HI: C & !Z
  - 101 GE: N==V
  - 110 GT: !Z & N==V
  - 111 AL: true, never inverted, so 1111 is also taken.
- br_taken, evaluated only when br_valid (otherwise 0):
  - B.cond: the decode result above.
  - CBZ: br_reg_zero.
  - CBNZ: !br_reg_zero.
  - B: 1.
  - Flags play no part in CBZ/CBNZ/B.
- flush with br_valid forces br_taken=0.

## Timing
- Reset (synchronous):
  - pend_valid=0, arch_nzcv=RESET_NZCV.
  - nzcv_arch=RESET_NZCV, nzcv_fwd=RESET_NZCV.
  - br_taken=0.
- br_taken and nzcv_fwd are combinational from inputs and state, with zero-cycle bypass latency.
- An EX setter becomes visible in nzcv_arch 2 edges after its EX cycle: capture at edge 1, commit at edge 2.
- Back-to-back setters: the pending stage is overwritten each cycle, commits stay in order, and the youngest setter wins the bypass.
- reset overrides flush and capture in the same cycle.
- A flush arriving while an entry is pending kills that entry. The EX instruction in the same cycle is also not captured.

## Structure
- Shared package (core_pkg):
  - NZCV bit indices: N=3, Z=2, C=1, V=0.
  - br_kind enum.
  - cond_e enum: EQ..AL/NV codes.
- Sub-module cond_eval: combinational mapping of {cond, nzcv} to pass. It is reused by conditional-select logic.
- The top level holds the pending/arch registers, the bypass mux, and the br_kind mux.

## Test plan
1. Reset, then B.cond EQ with no setters → nzcv_arch=0000, br_taken=0. NE → br_taken=1.
2. SUBS result 0 (ex_nzcv=0110) with B.EQ in the same cycle → br_taken=1 via EX bypass. Next cycle nzcv_arch is still 0000. The cycle after, nzcv_arch=0110.
3. Setter 1000 then setter 0001 back-to-back; B.LT issued in cycle 2 → uses 0001, N≠V, br_taken=1. Final nzcv_arch=0001.
4. Setter 0100 captured into pending, flush next cycle → nzcv_arch stays 0000. B.EQ during the flush cycle → br_taken=0.
5. CBZ with br_reg_zero=1 → 1. CBNZ with br_reg_zero=1 → 0. Both are unaffected by nzcv_fwd=0100.
6. Sweep all 16 cond values × all 16 NZCV values against the decode rules. cond=1111 and cond=1110 → taken for every NZCV.

Source files
------------

// File: rtl/nzcv_cond_unit_pkg.sv
// Shared definitions for the NZCV status path and branch resolution.
//   - NZCV bit positions inside the {N,Z,C,V} nibble
//   - br_kind_e : branch flavour presented for resolution
//   - cond_e    : AArch64 condition field encodings
package nzcv_cond_unit_pkg;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_CBZ  = 2'b01,
    BR_CBNZ = 2'b10,
    BR_B    = 2'b11
  } br_kind_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/nzcv_cond_unit_if.sv
// Bundle between the EX stage / branch unit and nzcv_cond_unit.
//   slave  : the flag unit (consumes EX flags and branch requests)
//   master : the pipeline side driving EX and branch requests
interface nzcv_cond_unit_if;
  import nzcv_cond_unit_pkg::*;

  logic     flush;
  logic     ex_valid;
  logic     ex_set_flags;
  logic [3:0] ex_nzcv;
  logic     br_valid;
  br_kind_e br_kind;
  logic [3:0] br_cond;
  logic     br_reg_zero;
  logic     br_taken;
  logic [3:0] nzcv_arch;
  logic [3:0] nzcv_fwd;

  modport slave (
    input  flush, ex_valid, ex_set_flags, ex_nzcv,
           br_valid, br_kind, br_cond, br_reg_zero,
    output br_taken, nzcv_arch, nzcv_fwd
  );

  modport master (
    output flush, ex_valid, ex_set_flags, ex_nzcv,
           br_valid, br_kind, br_cond, br_reg_zero,
    input  br_taken, nzcv_arch, nzcv_fwd
  );
endinterface

// File: rtl/nzcv_cond_unit_cond_eval.sv
// Pure combinational AArch64 condition check.
//   i_cond : condition field, i_nzcv : flags {N,Z,C,V}, o_pass : condition holds
// cond[3:1] selects the base test, cond[0] inverts it, except for 111x
// (AL/NV) which always passes.
module nzcv_cond_unit_cond_eval
  import nzcv_cond_unit_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v, w_base;

  assign w_n = i_nzcv[NZCV_N];
  assign w_z = i_nzcv[NZCV_Z];
  assign w_c = i_nzcv[NZCV_C];
  assign w_v = i_nzcv[NZCV_V];

  always_comb begin
    w_base = 1'b1;
    case (i_cond[3:1])
      3'b000: w_base = w_z;
      3'b001: w_base = w_c;
      3'b010: w_base = w_n;
      3'b011: w_base = w_v;
      3'b100: w_base = w_c & ~w_z;
      3'b101: w_base = (w_n == w_v);
      3'b110: w_base = ~w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
  end

  assign o_pass = (i_cond[3:1] == 3'b111) ? 1'b1 : (w_base ^ i_cond[0]);
endmodule

// File: rtl/nzcv_cond_unit.sv
// NZCV capture / commit and branch resolution.
//   clk, reset : core clock, synchronous active-high reset
//   s_bus      : EX flags in, branch request in, br_taken / nzcv_arch /
//                nzcv_fwd out
// EX flags land in a one-entry pending stage and commit to the
// architectural register one edge later. Branches read the youngest
// live flags through a zero-latency bypass.
module nzcv_cond_unit
  import nzcv_cond_unit_pkg::*;
#(
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  nzcv_cond_unit_if.slave    s_bus
);
  logic       r_pend_valid;
  logic [3:0] r_pend_nzcv;
  logic [3:0] r_arch_nzcv;

  logic       w_capture, w_pend_live, w_cond_pass;
  logic [3:0] w_fwd;

  // flush squashes both the EX setter and whatever is pending
  assign w_capture   = s_bus.ex_valid & s_bus.ex_set_flags & ~s_bus.flush;
  assign w_pend_live = r_pend_valid & ~s_bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_nzcv  <= 4'b0000;
      r_arch_nzcv  <= RESET_NZCV;
    end else begin
      r_pend_valid <= w_capture;
      if (w_capture)   r_pend_nzcv <= s_bus.ex_nzcv;
      if (w_pend_live) r_arch_nzcv <= r_pend_nzcv;
    end
  end

  // youngest valid source wins
  assign w_fwd = w_capture   ? s_bus.ex_nzcv :
                 w_pend_live ? r_pend_nzcv   : r_arch_nzcv;

  nzcv_cond_unit_cond_eval u_cond_eval (
    .i_cond (s_bus.br_cond),
    .i_nzcv (w_fwd),
    .o_pass (w_cond_pass)
  );

  always_comb begin
    s_bus.br_taken = 1'b0;
    if (s_bus.br_valid && !s_bus.flush) begin
      case (s_bus.br_kind)
        BR_COND: s_bus.br_taken = w_cond_pass;
        BR_CBZ:  s_bus.br_taken = s_bus.br_reg_zero;
        BR_CBNZ: s_bus.br_taken = ~s_bus.br_reg_zero;
        default: s_bus.br_taken = 1'b1;
      endcase
    end
  end

  assign s_bus.nzcv_arch = r_arch_nzcv;
  assign s_bus.nzcv_fwd  = w_fwd;
endmodule

// File: tb/tb_nzcv_cond_unit.sv
module tb_nzcv_cond_unit;
  import nzcv_cond_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  nzcv_cond_unit_if bus ();

  nzcv_cond_unit #(.RESET_NZCV(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .s_bus (bus)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.flush        = 1'b0;
    bus.ex_valid     = 1'b0;
    bus.ex_set_flags = 1'b0;
    bus.ex_nzcv      = 4'b0000;
    bus.br_valid     = 1'b0;
    bus.br_kind      = BR_COND;
    bus.br_cond      = 4'b0000;
    bus.br_reg_zero  = 1'b0;
  endtask

  task automatic setter(input logic [3:0] f);
    bus.ex_valid     = 1'b1;
    bus.ex_set_flags = 1'b1;
    bus.ex_nzcv      = f;
  endtask

  task automatic branch(input br_kind_e k, input logic [3:0] c, input logic rz);
    bus.br_valid    = 1'b1;
    bus.br_kind     = k;
    bus.br_cond     = c;
    bus.br_reg_zero = rz;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Independent reference, written per full 4-bit code.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    idle();
    do_reset();

    // 1: reset state, EQ/NE on arch flags
    #1;
    chk("rst_arch",  bus.nzcv_arch, 4'b0000);
    chk("rst_fwd",   bus.nzcv_fwd,  4'b0000);
    chk("rst_taken", {3'b0, bus.br_taken}, 4'b0000);
    branch(BR_COND, 4'b0000, 1'b0); #1;
    chk("t1_eq", {3'b0, bus.br_taken}, 4'b0000);
    bus.br_cond = 4'b0001; #1;
    chk("t1_ne", {3'b0, bus.br_taken}, 4'b0001);

    // 2: SUBS -> 0 with B.EQ in the same cycle
    idle(); setter(4'b0110); branch(BR_COND, 4'b0000, 1'b0); #1;
    chk("t2_taken", {3'b0, bus.br_taken}, 4'b0001);
    chk("t2_fwd_ex", bus.nzcv_fwd, 4'b0110);
    chk("t2_arch0", bus.nzcv_arch, 4'b0000);
    tick(); idle(); #1;
    chk("t2_arch1", bus.nzcv_arch, 4'b0000);
    chk("t2_fwd_pend", bus.nzcv_fwd, 4'b0110);
    tick();
    chk("t2_arch2", bus.nzcv_arch, 4'b0110);
    chk("t2_fwd_arch", bus.nzcv_fwd, 4'b0110);

    // reset beats a live setter in the same cycle
    setter(4'b1111); reset = 1'b1; tick(); reset = 1'b0; idle(); #1;
    chk("rst_ovr_arch", bus.nzcv_arch, 4'b0000);
    chk("rst_ovr_fwd",  bus.nzcv_fwd,  4'b0000);

    // 3: back-to-back setters, B.LT uses the youngest
    setter(4'b1000); tick();
    setter(4'b0001); branch(BR_COND, 4'b1011, 1'b0); #1;
    chk("t3_fwd", bus.nzcv_fwd, 4'b0001);
    chk("t3_lt",  {3'b0, bus.br_taken}, 4'b0001);
    bus.br_cond = 4'b1010; #1;
    chk("t3_ge",  {3'b0, bus.br_taken}, 4'b0000);
    tick(); idle(); #1;
    chk("t3_arch_mid", bus.nzcv_arch, 4'b1000);
    tick();
    chk("t3_arch_fin", bus.nzcv_arch, 4'b0001);

    // 4: pending entry killed by flush
    do_reset();
    setter(4'b0100); tick();
    idle(); bus.flush = 1'b1; setter(4'b0010); branch(BR_COND, 4'b0000, 1'b0); #1;
    chk("t4_eq_flush", {3'b0, bus.br_taken}, 4'b0000);
    chk("t4_fwd_flush", bus.nzcv_fwd, 4'b0000);
    bus.br_kind = BR_B; #1;
    chk("t4_b_flush", {3'b0, bus.br_taken}, 4'b0000);
    tick(); idle(); #1;
    chk("t4_arch1", bus.nzcv_arch, 4'b0000);
    chk("t4_fwd1",  bus.nzcv_fwd,  4'b0000);
    tick();
    chk("t4_arch2", bus.nzcv_arch, 4'b0000);

    // 5: CBZ/CBNZ/B ignore flags
    setter(4'b0100);
    branch(BR_CBZ, 4'b0001, 1'b1); #1;
    chk("t5_fwd", bus.nzcv_fwd, 4'b0100);
    chk("t5_cbz1",  {3'b0, bus.br_taken}, 4'b0001);
    branch(BR_CBNZ, 4'b0001, 1'b1); #1;
    chk("t5_cbnz1", {3'b0, bus.br_taken}, 4'b0000);
    branch(BR_CBZ, 4'b0000, 1'b0); #1;
    chk("t5_cbz0",  {3'b0, bus.br_taken}, 4'b0000);
    branch(BR_CBNZ, 4'b0000, 1'b0); #1;
    chk("t5_cbnz0", {3'b0, bus.br_taken}, 4'b0001);
    branch(BR_B, 4'b0001, 1'b0); #1;
    chk("t5_b", {3'b0, bus.br_taken}, 4'b0001);
    bus.br_valid = 1'b0; #1;
    chk("t5_novalid", {3'b0, bus.br_taken}, 4'b0000);

    // 6: full cond x nzcv sweep via the EX bypass
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        setter(f[3:0]);
        branch(BR_COND, c[3:0], 1'b0); #1;
        chk($sformatf("sweep_c%0h_f%0h", c, f), {3'b0, bus.br_taken},
            {3'b0, ref_pass(c[3:0], f[3:0])});
      end
    end

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
